// File: rtl/sargantana_icache_pkg.sv
// Shared types, constants and tree-PLRU helpers for the icache victim selector.
// Helpers are sized for the largest supported associativity (16 ways) and take
// the real tree depth as an argument; callers zero-extend / truncate their state.
package sargantana_icache_pkg;

  localparam int unsigned ICACHE_MAX_WAY   = 16;
  localparam int unsigned ICACHE_MAX_WAY_W = 4;

  typedef logic [ICACHE_MAX_WAY-2:0]   icache_plru_t;
  typedef logic [ICACHE_MAX_WAY_W-1:0] icache_way_t;

  localparam logic [7:0] ICACHE_LFSR_SEED = 8'h01;

  // Walk heap-ordered node bits from the root; each bit picks the subtree holding the victim.
  function automatic icache_way_t plru_victim(input icache_plru_t plru,
                                              input int unsigned  way_w);
    icache_way_t way;
    logic [4:0]  node;
    logic        dir;
    way  = '0;
    node = '0;
    for (int unsigned lvl = 0; lvl < ICACHE_MAX_WAY_W; lvl++) begin
      if (lvl < way_w) begin
        dir  = plru[node[3:0]];
        way  = {way[ICACHE_MAX_WAY_W-2:0], dir};
        node = {node[3:0], 1'b0} + 5'd1 + {4'b0, dir};
      end
    end
    return way;
  endfunction

  function automatic icache_plru_t plru_touch(input icache_plru_t plru,
                                              input icache_way_t  way,
                                              input int unsigned  way_w);
    icache_plru_t res;
    icache_way_t  sh;
    logic [4:0]   node;
    logic         dir;
    res  = plru;
    node = '0;
    for (int unsigned lvl = 0; lvl < ICACHE_MAX_WAY_W; lvl++) begin
      if (lvl < way_w) begin
        sh             = way >> (way_w - 1 - lvl);
        dir            = sh[0];
        res[node[3:0]] = ~dir;
        node           = {node[3:0], 1'b0} + 5'd1 + {4'b0, dir};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sargantana_icache_prio_enc.sv
// Generic lowest-set-bit priority encoder with an empty flag.
module sargantana_icache_prio_enc #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             empty_o
);

  logic found;

  always_comb begin
    idx_o = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (vec_i[i] && !found) begin
        idx_o = IDX_W'(i);
        found = 1'b1;
      end
    end
    empty_o = ~found;
  end

endmodule

// File: rtl/sargantana_icache_victim_sel.sv
// Icache way-replacement selector: lowest invalid way first, else per-set tree-PLRU.
// Build option ICACHE_VICTIM_LFSR_EN swaps the PLRU array for one shared 8-bit LFSR.
module sargantana_icache_victim_sel
  import sargantana_icache_pkg::*;
#(
  parameter int unsigned ICACHE_N_WAY  = 4,
  parameter int unsigned ICACHE_N_SETS = 64,
  parameter int unsigned WAY_W         = $clog2(ICACHE_N_WAY),
  parameter int unsigned SET_W         = $clog2(ICACHE_N_SETS)
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    req_valid_i,
  input  logic [SET_W-1:0]        req_set_i,
  input  logic [ICACHE_N_WAY-1:0] req_way_valid_i,
  input  logic                    hit_valid_i,
  input  logic [SET_W-1:0]        hit_set_i,
  input  logic [WAY_W-1:0]        hit_way_i,
  input  logic                    flush_i,
  output logic                    victim_valid_o,
  output logic [WAY_W-1:0]        victim_way_o,
  output logic                    victim_invalid_o,
  output logic                    empty_o
);

  logic [ICACHE_N_WAY-1:0] way_invalid;
  logic [WAY_W-1:0]        inv_way;
  logic                    inv_none;
  logic [WAY_W-1:0]        full_way;
  logic [WAY_W-1:0]        sel_way;
  logic                    sel_invalid;

  logic             victim_valid_q,   victim_valid_d;
  logic [WAY_W-1:0] victim_way_q,     victim_way_d;
  logic             victim_invalid_q, victim_invalid_d;

  assign way_invalid = ~req_way_valid_i;
  assign empty_o     = ~|req_way_valid_i;

  sargantana_icache_prio_enc #(
    .N     (ICACHE_N_WAY),
    .IDX_W (WAY_W)
  ) u_inv_enc (
    .vec_i   (way_invalid),
    .idx_o   (inv_way),
    .empty_o (inv_none)
  );

`ifdef ICACHE_VICTIM_LFSR_EN
  logic [7:0] lfsr_q, lfsr_d;
  logic       lfsr_fb;
  logic       unused_lookup;

  assign unused_lookup = ^{hit_valid_i, hit_set_i, hit_way_i, flush_i};

  always_comb begin
    lfsr_fb  = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    lfsr_d   = req_valid_i ? {lfsr_q[6:0], lfsr_fb} : lfsr_q;
    full_way = lfsr_q[WAY_W-1:0];
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) lfsr_q <= ICACHE_LFSR_SEED;
    else         lfsr_q <= lfsr_d;
  end
`else
  logic [ICACHE_N_WAY-2:0] plru_q [ICACHE_N_SETS];
  logic [ICACHE_N_WAY-2:0] plru_hit_d;
  logic [ICACHE_N_WAY-2:0] plru_req_d;
  icache_plru_t            req_rd, hit_rd, hit_upd, req_base, req_upd;
  icache_way_t             plru_way;

  always_comb begin
    req_rd   = icache_plru_t'(plru_q[req_set_i]);
    hit_rd   = icache_plru_t'(plru_q[hit_set_i]);
    plru_way = plru_victim(req_rd, WAY_W);
    full_way = plru_way[WAY_W-1:0];
    hit_upd  = plru_touch(hit_rd, icache_way_t'(hit_way_i), WAY_W);
    // Same-set hit lands first so the victim path overrides the shared nodes.
    req_base = (hit_valid_i && (hit_set_i == req_set_i)) ? hit_upd : req_rd;
    req_upd  = plru_touch(req_base, icache_way_t'(sel_way), WAY_W);
    plru_hit_d = hit_upd[ICACHE_N_WAY-2:0];
    plru_req_d = req_upd[ICACHE_N_WAY-2:0];
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int unsigned s = 0; s < ICACHE_N_SETS; s++) plru_q[s] <= '0;
    end else if (flush_i) begin
      for (int unsigned s = 0; s < ICACHE_N_SETS; s++) plru_q[s] <= '0;
    end else begin
      if (hit_valid_i) plru_q[hit_set_i] <= plru_hit_d;
      if (req_valid_i) plru_q[req_set_i] <= plru_req_d;
    end
  end
`endif

  always_comb begin
    sel_way          = inv_none ? full_way : inv_way;
    sel_invalid      = ~inv_none;
    victim_valid_d   = req_valid_i;
    victim_way_d     = req_valid_i ? sel_way     : victim_way_q;
    victim_invalid_d = req_valid_i ? sel_invalid : victim_invalid_q;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      victim_valid_q   <= 1'b0;
      victim_way_q     <= '0;
      victim_invalid_q <= 1'b0;
    end else begin
      victim_valid_q   <= victim_valid_d;
      victim_way_q     <= victim_way_d;
      victim_invalid_q <= victim_invalid_d;
    end
  end

  assign victim_valid_o   = victim_valid_q;
  assign victim_way_o     = victim_way_q;
  assign victim_invalid_o = victim_invalid_q;

endmodule

// File: tb/tb_sargantana_icache_victim_sel.sv
// Randomised and directed bench for the 4-way, 64-set victim selector (default PLRU build).
module tb_sargantana_icache_victim_sel;

  localparam int N    = 4;
  localparam int SETS = 64;

  logic       clk_i = 1'b0;
  logic       rstn_i;
  logic       req_valid_i;
  logic [5:0] req_set_i;
  logic [3:0] req_way_valid_i;
  logic       hit_valid_i;
  logic [5:0] hit_set_i;
  logic [1:0] hit_way_i;
  logic       flush_i;
  logic       victim_valid_o;
  logic [1:0] victim_way_o;
  logic       victim_invalid_o;
  logic       empty_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: one bit per tree node; 1 = victim lies in the upper half of that node's range.
  bit tree [SETS][N];

  sargantana_icache_victim_sel #(
    .ICACHE_N_WAY  (N),
    .ICACHE_N_SETS (SETS)
  ) dut (
    .clk_i            (clk_i),
    .rstn_i           (rstn_i),
    .req_valid_i      (req_valid_i),
    .req_set_i        (req_set_i),
    .req_way_valid_i  (req_way_valid_i),
    .hit_valid_i      (hit_valid_i),
    .hit_set_i        (hit_set_i),
    .hit_way_i        (hit_way_i),
    .flush_i          (flush_i),
    .victim_valid_o   (victim_valid_o),
    .victim_way_o     (victim_way_o),
    .victim_invalid_o (victim_invalid_o),
    .empty_o          (empty_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int mdl_victim(input int s);
    int lo, size, node, half;
    lo = 0; size = N; node = 0;
    while (size > 1) begin
      half = size / 2;
      if (tree[s][node]) begin
        lo   = lo + half;
        node = 2 * node + 2;
      end else begin
        node = 2 * node + 1;
      end
      size = half;
    end
    return lo;
  endfunction

  task automatic mdl_touch(input int s, input int w);
    int lo, size, node, half;
    lo = 0; size = N; node = 0;
    while (size > 1) begin
      half = size / 2;
      if (w < lo + half) begin
        tree[s][node] = 1'b1;
        node = 2 * node + 1;
      end else begin
        tree[s][node] = 1'b0;
        lo   = lo + half;
        node = 2 * node + 2;
      end
      size = half;
    end
  endtask

  task automatic mdl_clear();
    foreach (tree[s, n]) tree[s][n] = 1'b0;
  endtask

  task automatic idle_inputs();
    req_valid_i = 1'b0; req_set_i = '0; req_way_valid_i = '0;
    hit_valid_i = 1'b0; hit_set_i = '0; hit_way_i = '0; flush_i = 1'b0;
  endtask

  // One clock: apply inputs, predict, advance the model, then check the registered response.
  task automatic drive_cycle(input bit rq, input int rs, input logic [3:0] rv,
                             input bit h, input int hs, input int hw, input bit fl);
    int exp_w;
    bit exp_inv;
    req_valid_i = rq; req_set_i = 6'(rs); req_way_valid_i = rv;
    hit_valid_i = h;  hit_set_i = 6'(hs); hit_way_i = 2'(hw); flush_i = fl;
    #1;
    check_eq("empty", empty_o, (rv == 4'b0000));
    exp_inv = 1'b0;
    exp_w   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!rv[i]) begin
        exp_w   = i;
        exp_inv = 1'b1;
      end
    end
    if (!exp_inv) exp_w = mdl_victim(rs);
    if (fl) begin
      mdl_clear();
    end else begin
      if (h)  mdl_touch(hs, hw);
      if (rq) mdl_touch(rs, exp_w);
    end
    @(posedge clk_i);
    #1;
    check_eq("valid", victim_valid_o, rq);
    if (rq) begin
      check_eq("way", victim_way_o, exp_w);
      check_eq("invalid", victim_invalid_o, exp_inv);
    end
  endtask

  initial begin
    idle_inputs();
    mdl_clear();
    rstn_i = 1'b0;
    #23;
    check_eq("rst_valid", victim_valid_o, 0);
    check_eq("rst_way", victim_way_o, 0);
    check_eq("rst_inv", victim_invalid_o, 0);
    @(negedge clk_i) rstn_i = 1'b1;
    @(posedge clk_i);
    #1;
    check_eq("post_rst_valid", victim_valid_o, 0);

    drive_cycle(1, 5, 4'hF, 0, 0, 0, 0);
    check_eq("tp_set5_first", victim_way_o, 0);
    drive_cycle(1, 5, 4'hF, 0, 0, 0, 0);
    check_eq("tp_set5_second", victim_way_o, 2);

    drive_cycle(1, 20, 4'b1011, 0, 0, 0, 0);
    check_eq("tp_inv_way", victim_way_o, 2);
    check_eq("tp_inv_flag", victim_invalid_o, 1);
    drive_cycle(1, 21, 4'b0000, 0, 0, 0, 0);
    check_eq("tp_allinv_way", victim_way_o, 0);

    drive_cycle(0, 0, 4'hF, 1, 3, 0, 0);
    drive_cycle(0, 0, 4'hF, 1, 3, 2, 0);
    drive_cycle(1, 3, 4'hF, 0, 0, 0, 0);
    check_eq("tp_hits_set3", victim_way_o, 1);
    drive_cycle(1, 4, 4'hF, 0, 0, 0, 0);
    check_eq("tp_isolation_set4", victim_way_o, 0);

    drive_cycle(1, 7, 4'hF, 1, 7, 1, 0);
    check_eq("tp_same_cycle_prehit", victim_way_o, 0);
    drive_cycle(1, 7, 4'hF, 0, 0, 0, 0);
    check_eq("tp_same_cycle_after", victim_way_o, 2);

    drive_cycle(0, 0, 4'hF, 1, 10, 3, 0);
    drive_cycle(0, 0, 4'hF, 1, 11, 1, 0);
    drive_cycle(1, 3, 4'hF, 0, 0, 0, 1);
    check_eq("tp_flush_preflush", victim_way_o, 3);
    for (int s = 0; s < SETS; s++) begin
      drive_cycle(1, s, 4'hF, 0, 0, 0, 0);
      check_eq("tp_after_flush", victim_way_o, 0);
    end

    // Reset lands before the edge that would sample the request.
    req_valid_i = 1'b1; req_set_i = 6'd9; req_way_valid_i = 4'hF;
    hit_valid_i = 1'b0; flush_i = 1'b0;
    @(negedge clk_i) rstn_i = 1'b0;
    @(posedge clk_i);
    #1;
    check_eq("rst_mid_no_pulse", victim_valid_o, 0);
    idle_inputs();
    mdl_clear();
    @(negedge clk_i) rstn_i = 1'b1;
    @(posedge clk_i);
    #1;
    check_eq("rst_mid_still_idle", victim_valid_o, 0);

    // Reset arriving while a response is up drops it immediately.
    req_valid_i = 1'b1; req_set_i = 6'd9; req_way_valid_i = 4'hF;
    @(posedge clk_i);
    #1;
    check_eq("rst_pulse_up", victim_valid_o, 1);
    idle_inputs();
    rstn_i = 1'b0;
    #1;
    check_eq("rst_pulse_drop", victim_valid_o, 0);
    mdl_clear();
    @(negedge clk_i) rstn_i = 1'b1;
    @(posedge clk_i);
    #1;

    for (int k = 0; k < 500; k++) begin
      bit         rq, h, fl;
      logic [3:0] rv;
      rq = ($urandom_range(0, 9) < 7);
      h  = $urandom_range(0, 1);
      fl = ($urandom_range(0, 31) == 0);
      rv = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
      drive_cycle(rq, $urandom_range(0, 7), rv, h, $urandom_range(0, 7),
                  $urandom_range(0, N - 1), fl);
    end

    idle_inputs();
    @(posedge clk_i);
    #1;
    check_eq("final_idle", victim_valid_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
